// File: rtl/change_dispenser.sv
// Coin payout sequencer: splits a refund (in 5rs units) into 10rs/5rs hopper
// ejections using a 4-phase req/ack handshake, with a stall timeout and fault latch.
module change_dispenser #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refund_valid,
    input  logic [3:0] refund_amt,
    output logic       refund_ready,
    output logic       hop10_req,
    output logic       hop5_req,
    input  logic       hop_ack,
    input  logic       hop10_empty,
    input  logic       hop5_empty,
    input  logic       fault_clr,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] remaining
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_REQ10,
        S_REQ5,
        S_ACKLOW,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        refund_ready = 1'b0;
        hop10_req    = 1'b0;
        hop5_req     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                refund_ready = 1'b1;
                busy         = 1'b0;
                if (refund_valid) begin
                    rem_d   = refund_amt;
                    state_d = (refund_amt > 4'd10) ? S_FAULT : S_SEL;
                end
            end
            S_SEL: begin
                // Empty flags are only looked at here; the count restarts for the coming REQ state
                cnt_d = '0;
                if (rem_q == 4'd0)
                    state_d = S_DONE;
                else if (rem_q >= 4'd2 && !hop10_empty)
                    state_d = S_REQ10;
                else if (!hop5_empty)
                    state_d = S_REQ5;
                else
                    state_d = S_FAULT;
            end
            S_REQ10, S_REQ5: begin
                hop10_req = (state_q == S_REQ10);
                hop5_req  = (state_q == S_REQ5);
                if (hop_ack) begin
                    rem_d   = rem_q - ((state_q == S_REQ10) ? 4'd2 : 4'd1);
                    cnt_d   = '0;
                    state_d = S_ACKLOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACKLOW: begin
                if (!hop_ack)
                    state_d = S_SEL;
                else if (cnt_q == CNT_LAST)
                    state_d = S_FAULT;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                fault = 1'b1;
                if (fault_clr) begin
                    rem_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a sequential payout model predicts every output each
// cycle; directed scenarios add hand-computed coin, remaining and pulse expectations.
module tb_change_dispenser;

    localparam int T = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       refund_valid;
    logic [3:0] refund_amt;
    logic       refund_ready;
    logic       hop10_req;
    logic       hop5_req;
    logic       hop_ack;
    logic       hop10_empty;
    logic       hop5_empty;
    logic       fault_clr;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] remaining;

    always #5 clk = ~clk;

    change_dispenser #(.TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .refund_ready (refund_ready),
        .hop10_req    (hop10_req),
        .hop5_req     (hop5_req),
        .hop_ack      (hop_ack),
        .hop10_empty  (hop10_empty),
        .hop5_empty   (hop5_empty),
        .fault_clr    (fault_clr),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .remaining    (remaining)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int e_ready, e_busy, e_h10, e_h5, e_done, e_fault, e_rem;

    task automatic m_show(input int r, input int b, input int h10, input int h5,
                          input int d, input int f);
        e_ready = r; e_busy = b; e_h10 = h10; e_h5 = h5; e_done = d; e_fault = f;
    endtask

    task automatic m_fault();
        m_show(0, 1, 0, 0, 0, 1);
        forever begin
            @(posedge clk);
            if (!reset_n || fault_clr) return;
        end
    endtask

    task automatic m_wait_ack(input logic level, output bit ok, output bit rst);
        ok = 1'b0;
        rst = 1'b0;
        for (int n = 0; n < T; n++) begin
            @(posedge clk);
            if (!reset_n) begin rst = 1'b1; return; end
            if (hop_ack == level) begin ok = 1'b1; return; end
        end
    endtask

    task automatic m_txn(input int amt);
        int coin;
        bit ok, rst;
        e_rem = amt;
        if (amt > 10) begin m_fault(); return; end
        forever begin
            m_show(0, 1, 0, 0, 0, 0);
            @(posedge clk);
            if (!reset_n) return;
            if (e_rem == 0) begin
                m_show(0, 1, 0, 0, 1, 0);
                @(posedge clk);
                return;
            end
            if (e_rem >= 2 && !hop10_empty) coin = 2;
            else if (e_rem >= 1 && !hop5_empty) coin = 1;
            else begin m_fault(); return; end
            m_show(0, 1, int'(coin == 2), int'(coin == 1), 0, 0);
            m_wait_ack(1'b1, ok, rst);
            if (rst) return;
            if (!ok) begin m_fault(); return; end
            e_rem -= coin;
            m_show(0, 1, 0, 0, 0, 0);
            m_wait_ack(1'b0, ok, rst);
            if (rst) return;
            if (!ok) begin m_fault(); return; end
        end
    endtask

    initial begin : model
        forever begin
            e_rem = 0;
            m_show(1, 0, 0, 0, 0, 0);
            @(posedge clk);
            if (reset_n && refund_valid) m_txn(int'(refund_amt));
        end
    end

    // ---------------- compare + monitors ----------------
    int rem_hist[$];
    int coins[$];
    int n_done  = 0;
    int n_h5_hi = 0;

    initial begin : compare
        int last_rem = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst ready", int'(refund_ready), 1);
                check("rst busy",  int'(busy), 0);
                check("rst req",   int'(hop10_req | hop5_req), 0);
                check("rst flags", int'(done | fault), 0);
                check("rst rem",   int'(remaining), 0);
            end else begin
                check("ready", int'(refund_ready), e_ready);
                check("busy",  int'(busy), e_busy);
                check("h10",   int'(hop10_req), e_h10);
                check("h5",    int'(hop5_req), e_h5);
                check("done",  int'(done), e_done);
                check("fault", int'(fault), e_fault);
                check("rem",   int'(remaining), e_rem);
            end
            if (int'(remaining) != last_rem) begin
                last_rem = int'(remaining);
                rem_hist.push_back(last_rem);
            end
            n_done  += int'(done);
            n_h5_hi += int'(hop5_req);
        end
    end

    // ---------------- hopper emulation: ack 2 cycles after req ----------------
    bit hop_auto = 1'b1;

    initial begin : hopper
        int w = 0;
        hop_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!hop_auto || !(hop10_req || hop5_req)) begin
                w = 0;
                hop_ack = 1'b0;
            end else begin
                w++;
                if (w >= 2 && !hop_ack) begin
                    hop_ack = 1'b1;
                    coins.push_back(hop10_req ? 10 : 5);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int amt);
        step();
        refund_valid = 1'b1;
        refund_amt   = 4'(amt);
        step();
        refund_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!refund_ready && n < budget) begin step(); n++; end
        check(name, int'(refund_ready), 1);
    endtask

    task automatic wait_fault(input string name, input int budget);
        int n = 0;
        while (!fault && n < budget) begin step(); n++; end
        check(name, int'(fault), 1);
    endtask

    task automatic clear_fault();
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
    endtask

    initial begin : stim
        int c0, r0, d0, h0, tens;
        reset_n      = 1'b0;
        refund_valid = 1'b0;
        refund_amt   = 4'd0;
        hop10_empty  = 1'b0;
        hop5_empty   = 1'b0;
        fault_clr    = 1'b0;
        hop_auto     = 1'b1;
        repeat (3) step();
        check("reset ready", int'(refund_ready), 1);
        check("reset rem",   int'(remaining), 0);
        reset_n = 1'b1;
        step();

        // 3 units: one 10rs then one 5rs, remaining 3 -> 1 -> 0
        c0 = coins.size(); r0 = rem_hist.size(); d0 = n_done;
        start(3);
        step();
        refund_valid = 1'b1;
        refund_amt   = 4'd5;
        step();
        refund_valid = 1'b0;
        wait_idle("amt3 idle", 100);
        check("amt3 coins", coins.size() - c0, 2);
        if (coins.size() - c0 == 2) begin
            check("amt3 coin0", coins[c0], 10);
            check("amt3 coin1", coins[c0 + 1], 5);
        end
        check("amt3 hist len", rem_hist.size() - r0, 3);
        if (rem_hist.size() - r0 == 3) begin
            check("amt3 rem a", rem_hist[r0], 3);
            check("amt3 rem b", rem_hist[r0 + 1], 1);
            check("amt3 rem c", rem_hist[r0 + 2], 0);
        end
        check("amt3 done", n_done - d0, 1);

        // 4 units with empty 10rs hopper: four 5rs coins
        hop10_empty = 1'b1;
        c0 = coins.size(); d0 = n_done;
        start(4);
        wait_idle("amt4 idle", 100);
        check("amt4 coins", coins.size() - c0, 4);
        tens = 0;
        for (int i = c0; i < coins.size(); i++) if (coins[i] == 10) tens++;
        check("amt4 tens", tens, 0);
        check("amt4 done", n_done - d0, 1);
        hop10_empty = 1'b0;

        // both hoppers empty: fault two edges after accept
        hop10_empty = 1'b1;
        hop5_empty  = 1'b1;
        start(2);
        step();
        check("empty fault", int'(fault), 1);
        check("empty rem",   int'(remaining), 2);
        check("empty req",   int'(hop10_req | hop5_req), 0);
        clear_fault();
        check("clr ready", int'(refund_ready), 1);
        check("clr rem",   int'(remaining), 0);
        hop10_empty = 1'b0;
        hop5_empty  = 1'b0;

        // no ack: 5rs request held for exactly T cycles, then fault
        hop_auto = 1'b0;
        h0 = n_h5_hi;
        start(1);
        wait_fault("tmo fault", T + 20);
        check("tmo h5 cycles", n_h5_hi - h0, T);
        check("tmo h5 low",    int'(hop5_req), 0);
        check("tmo rem",       int'(remaining), 1);
        clear_fault();
        hop_auto = 1'b1;

        // zero refund completes with no coins; 11 is rejected
        c0 = coins.size(); d0 = n_done;
        start(0);
        wait_idle("amt0 idle", 20);
        check("amt0 done",  n_done - d0, 1);
        check("amt0 coins", coins.size() - c0, 0);
        start(11);
        check("amt11 fault", int'(fault), 1);
        check("amt11 req",   int'(hop10_req | hop5_req), 0);
        clear_fault();

        // 5rs hopper empty with odd amount: one 10rs coin then fault with 1 unpaid
        hop5_empty = 1'b1;
        c0 = coins.size();
        start(3);
        wait_fault("odd fault", 100);
        check("odd coins", coins.size() - c0, 1);
        check("odd rem",   int'(remaining), 1);
        clear_fault();
        hop5_empty = 1'b0;

        // 10 units: five 10rs coins
        c0 = coins.size(); d0 = n_done;
        start(10);
        wait_idle("amt10 idle", 200);
        check("amt10 coins", coins.size() - c0, 5);
        check("amt10 done",  n_done - d0, 1);

        // async reset while 10rs request is up, then accept on first edge
        hop_auto = 1'b0;
        start(10);
        step();
        check("pre-rst h10", int'(hop10_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async h10", int'(hop10_req), 0);
        check("async ready", int'(refund_ready), 1);
        check("async rem", int'(remaining), 0);
        hop_auto     = 1'b1;
        refund_valid = 1'b1;
        refund_amt   = 4'd0;
        step();
        step();
        d0 = n_done;
        reset_n = 1'b1;
        step();
        refund_valid = 1'b0;
        check("first-edge busy", int'(busy), 1);
        wait_idle("post-rst idle", 20);
        check("post-rst done", n_done - d0, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
